// File: rtl/glb_fifo_arbiter_if.sv
// Bundle of the FIFO request/grant lines and the GLB access port seen by glb_fifo_arbiter.
// The arbiter uses the slave modport; the request side uses master.
interface glb_fifo_arbiter_if #(
    parameter int NUM_IFMAP = 32,
    parameter int NUM_IPSUM = 32,
    parameter int NUM_OPSUM = 32,
    parameter int IDX_W     = 5
);
    logic                 arb_en_i;
    logic [NUM_IFMAP-1:0] ifmap_req_i;
    logic [NUM_IPSUM-1:0] ipsum_req_i;
    logic [NUM_OPSUM-1:0] opsum_req_i;
    logic [NUM_IFMAP-1:0] ifmap_gnt_o;
    logic [NUM_IPSUM-1:0] ipsum_gnt_o;
    logic [NUM_OPSUM-1:0] opsum_gnt_o;
    logic                 glb_ready_i;
    logic                 glb_en_o;
    logic                 glb_we_o;
    logic [1:0]           glb_class_o;
    logic [IDX_W-1:0]     glb_idx_o;
    logic [NUM_IFMAP-1:0] ifmap_rvalid_o;
    logic [NUM_IPSUM-1:0] ipsum_rvalid_o;
    logic                 busy_o;

    modport master (
        output arb_en_i, ifmap_req_i, ipsum_req_i, opsum_req_i, glb_ready_i,
        input  ifmap_gnt_o, ipsum_gnt_o, opsum_gnt_o, glb_en_o, glb_we_o,
        input  glb_class_o, glb_idx_o, ifmap_rvalid_o, ipsum_rvalid_o, busy_o
    );

    modport slave (
        input  arb_en_i, ifmap_req_i, ipsum_req_i, opsum_req_i, glb_ready_i,
        output ifmap_gnt_o, ipsum_gnt_o, opsum_gnt_o, glb_en_o, glb_we_o,
        output glb_class_o, glb_idx_o, ifmap_rvalid_o, ipsum_rvalid_o, busy_o
    );
endinterface

// File: rtl/glb_fifo_arbiter.sv
// Single-port GLB arbiter: class priority with starvation boost, round-robin per class,
// and fixed-latency routing of read-return valids back to the requesting FIFO.
module glb_fifo_arbiter #(
    parameter int NUM_IFMAP    = 32,
    parameter int NUM_IPSUM    = 32,
    parameter int NUM_OPSUM    = 32,
    parameter int RD_LAT       = 2,
    parameter int STARVE_LIMIT = 8,
    parameter int IDX_W        = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    glb_fifo_arbiter_if.slave  bus
);
    localparam int MAXN_A = (NUM_IFMAP > NUM_IPSUM) ? NUM_IFMAP : NUM_IPSUM;
    localparam int MAXN   = (MAXN_A > NUM_OPSUM) ? MAXN_A : NUM_OPSUM;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    // Final latency stage is the rvalid register itself, so only RD_LAT-1 tuple stages.
    localparam int PD     = (RD_LAT > 1) ? RD_LAT - 1 : 1;
    localparam logic [1:0] C_IFMAP = 2'd0;
    localparam logic [1:0] C_IPSUM = 2'd1;
    localparam logic [1:0] C_OPSUM = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    function automatic logic [IDX_W-1:0] rr_pick(input logic [MAXN-1:0] req, input int n,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               cand;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= MAXN; k++) begin
            cand = (32'(last) + k) % n;
            if (k <= n && !found && req[cand]) begin
                pick  = cand[IDX_W-1:0];
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt, input logic en,
                                                  input logic can, input logic has_req,
                                                  input logic granted);
        if (!en)                return cnt;
        else if (!has_req)      return '0;
        else if (!can)          return cnt;
        else if (granted)       return '0;
        else if (cnt == CNT_MAX) return cnt;
        else                    return cnt + CNT_W'(1);
    endfunction

    logic                 w_any_if, w_any_ip, w_any_op, w_can_issue;
    logic                 w_boost_if, w_boost_ip, w_boost_op, w_rd_grant;
    logic [1:0]           w_sel;
    logic [MAXN-1:0]      w_req_if, w_req_ip, w_req_op;
    logic [IDX_W-1:0]     w_pick_if, w_pick_ip, w_pick_op, w_pick, w_idx;
    logic [NUM_IFMAP-1:0] w_gnt_if, w_ifmap_rv_nxt;
    logic [NUM_IPSUM-1:0] w_gnt_ip, w_ipsum_rv_nxt;
    logic [NUM_OPSUM-1:0] w_gnt_op;
    logic                 w_tail_v;
    logic [1:0]           w_tail_c;
    logic [IDX_W-1:0]     w_tail_i;

    logic [CNT_W-1:0]     r_cnt_if, r_cnt_ip, r_cnt_op;
    logic [IDX_W-1:0]     r_last_if, r_last_ip, r_last_op;
    logic [PD-1:0]        r_pv;
    logic [1:0]           r_pc [PD];
    logic [IDX_W-1:0]     r_pi [PD];
    logic [NUM_IFMAP-1:0] r_ifmap_rv;
    logic [NUM_IPSUM-1:0] r_ipsum_rv;

    assign w_any_if    = |bus.ifmap_req_i;
    assign w_any_ip    = |bus.ipsum_req_i;
    assign w_any_op    = |bus.opsum_req_i;
    assign w_can_issue = bus.arb_en_i & bus.glb_ready_i & (w_any_if | w_any_ip | w_any_op);
    assign w_boost_if  = w_any_if & (r_cnt_if == CNT_MAX);
    assign w_boost_ip  = w_any_ip & (r_cnt_ip == CNT_MAX);
    assign w_boost_op  = w_any_op & (r_cnt_op == CNT_MAX);
    assign w_rd_grant  = w_can_issue & (w_sel != C_OPSUM);

    // Round-robin candidate per class, request vectors widened to a common width.
    always_comb begin
        w_req_if = '0;
        w_req_ip = '0;
        w_req_op = '0;
        w_req_if[NUM_IFMAP-1:0] = bus.ifmap_req_i;
        w_req_ip[NUM_IPSUM-1:0] = bus.ipsum_req_i;
        w_req_op[NUM_OPSUM-1:0] = bus.opsum_req_i;
        w_pick_if = rr_pick(w_req_if, NUM_IFMAP, r_last_if);
        w_pick_ip = rr_pick(w_req_ip, NUM_IPSUM, r_last_ip);
        w_pick_op = rr_pick(w_req_op, NUM_OPSUM, r_last_op);
    end

    // Class select: boosted classes (ifmap > ipsum > opsum) beat normal order (opsum > ipsum > ifmap).
    always_comb begin
        w_sel = C_IFMAP;
        if (w_boost_if)      w_sel = C_IFMAP;
        else if (w_boost_ip) w_sel = C_IPSUM;
        else if (w_boost_op) w_sel = C_OPSUM;
        else if (w_any_op)   w_sel = C_OPSUM;
        else if (w_any_ip)   w_sel = C_IPSUM;
        else                 w_sel = C_IFMAP;
    end

    // Grant decode and GLB strobe for the selected class.
    always_comb begin
        w_gnt_if = '0;
        w_gnt_ip = '0;
        w_gnt_op = '0;
        case (w_sel)
            C_IFMAP: w_pick = w_pick_if;
            C_IPSUM: w_pick = w_pick_ip;
            C_OPSUM: w_pick = w_pick_op;
            default: w_pick = '0;
        endcase
        w_idx = w_can_issue ? w_pick : '0;
        if (w_can_issue) begin
            case (w_sel)
                C_IFMAP: w_gnt_if[w_pick] = 1'b1;
                C_IPSUM: w_gnt_ip[w_pick] = 1'b1;
                C_OPSUM: w_gnt_op[w_pick] = 1'b1;
                default: w_gnt_if = '0;
            endcase
        end else begin
            w_gnt_if = '0;
        end
    end

    // Tail of the read-return pipe, decoded into the one-hot rvalid next state.
    always_comb begin
        w_ifmap_rv_nxt = '0;
        w_ipsum_rv_nxt = '0;
        if (RD_LAT == 1) begin
            w_tail_v = w_rd_grant;
            w_tail_c = w_sel;
            w_tail_i = w_idx;
        end else begin
            w_tail_v = r_pv[PD-1];
            w_tail_c = r_pc[PD-1];
            w_tail_i = r_pi[PD-1];
        end
        if (w_tail_v && w_tail_c == C_IFMAP)      w_ifmap_rv_nxt[w_tail_i] = 1'b1;
        else if (w_tail_v && w_tail_c == C_IPSUM) w_ipsum_rv_nxt[w_tail_i] = 1'b1;
        else                                      w_ifmap_rv_nxt = '0;
    end

    // Starvation counters and round-robin pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_if  <= '0;
            r_cnt_ip  <= '0;
            r_cnt_op  <= '0;
            r_last_if <= IDX_W'(NUM_IFMAP - 1);
            r_last_ip <= IDX_W'(NUM_IPSUM - 1);
            r_last_op <= IDX_W'(NUM_OPSUM - 1);
        end else begin
            r_cnt_if <= cnt_next(r_cnt_if, bus.arb_en_i, w_can_issue, w_any_if, w_sel == C_IFMAP);
            r_cnt_ip <= cnt_next(r_cnt_ip, bus.arb_en_i, w_can_issue, w_any_ip, w_sel == C_IPSUM);
            r_cnt_op <= cnt_next(r_cnt_op, bus.arb_en_i, w_can_issue, w_any_op, w_sel == C_OPSUM);
            if (w_can_issue && w_sel == C_IFMAP) r_last_if <= w_pick;
            if (w_can_issue && w_sel == C_IPSUM) r_last_ip <= w_pick;
            if (w_can_issue && w_sel == C_OPSUM) r_last_op <= w_pick;
        end
    end

    // Read-return pipe; advances every cycle and is flushed by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
            for (int s = 0; s < PD; s++) begin
                r_pc[s] <= 2'd0;
                r_pi[s] <= '0;
            end
            r_ifmap_rv <= '0;
            r_ipsum_rv <= '0;
        end else begin
            r_pv[0] <= w_rd_grant;
            r_pc[0] <= w_sel;
            r_pi[0] <= w_idx;
            for (int s = 1; s < PD; s++) begin
                r_pv[s] <= r_pv[s-1];
                r_pc[s] <= r_pc[s-1];
                r_pi[s] <= r_pi[s-1];
            end
            r_ifmap_rv <= w_ifmap_rv_nxt;
            r_ipsum_rv <= w_ipsum_rv_nxt;
        end
    end

    assign bus.ifmap_gnt_o    = w_gnt_if;
    assign bus.ipsum_gnt_o    = w_gnt_ip;
    assign bus.opsum_gnt_o    = w_gnt_op;
    assign bus.glb_en_o       = w_can_issue;
    assign bus.glb_we_o       = w_can_issue & (w_sel == C_OPSUM);
    assign bus.glb_class_o    = w_can_issue ? w_sel : 2'd0;
    assign bus.glb_idx_o      = w_idx;
    assign bus.ifmap_rvalid_o = r_ifmap_rv;
    assign bus.ipsum_rvalid_o = r_ipsum_rv;
    assign bus.busy_o         = w_any_if | w_any_ip | w_any_op | |r_ifmap_rv | |r_ipsum_rv |
                                ((RD_LAT > 1) && (|r_pv));
endmodule
